mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Single-port arbiter for the pipe_MIPS32 unified memory (MEM array, 1024 x 32).
- Shares one synchronous-read memory port between three requesters:
  - instruction fetch (IF stage)
  - data access (MEM stage LW/SW)
  - debug/loader port, which preloads programs and reads results.
- Runs on the clk1 phase. Adds a HALT mode in which the debug port owns memory exclusively after the CPU asserts HALTED.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive denied IF cycles after which IF gets top priority for one grant.

Ports:
- clk1  in  1  clock (single clock domain).
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dm_req / dm_we  in  1  data request; 1 = write.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt / dm_rvalid  out  1  data grant; load data valid.
- dm_rdata  out  DATA_W  load data.
- dbg_req / dbg_we  in  1  debug request; 1 = write.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt / dbg_rvalid  out  1  debug grant; read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- cpu_halted  in  1  HALTED flag from the CPU.
- mem_en / mem_we  out  1  memory access enable; write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.
- halt_mode  out  1  arbiter is in HALT state.

Behaviour:
- Reset (async, any time): state=RUN, starve_cnt=0, rd_owner=NONE.
  - All gnt, rvalid, mem_en, mem_we, halt_mode outputs are 0; all data/address outputs are 0.
  - A read pending at reset is dropped; no rvalid is issued.
- Grant timing: at most one grant per cycle.
  - The grant is combinational from the req inputs and registered state.
  - mem_* outputs are driven from the granted port in the same cycle.
  - A requester holds req, addr, we and wdata stable until it sees gnt.
- Write: completes in the grant cycle; no rvalid follows.
- Read: rd_owner is registered at grant.
  - The next cycle asserts exactly one *_rvalid, with *_rdata = mem_rdata.
  - Back-to-back reads are fully pipelined: one per cycle.
  - rdata outputs hold their last value when rvalid=0.
- RUN priority: dm > if > dbg.
  - Exception: when starve_cnt==STARVE_MAX and if_req=1, IF wins over dm.
  - dbg is granted only in cycles with no if_req and no dm_req.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when if_req=1 and if_gnt=0.
  - Clears on if_gnt, or when if_req=0.
- FSM states RUN and HALT:
  - RUN -> HALT when cpu_halted=1 and no read is outstanding (rd_owner==NONE after this cycle's rvalid). Until then, CPU reads may still complete.
  - HALT: if_gnt and dm_gnt are forced 0; dbg_req is granted every cycle it is asserted; halt_mode=1.
  - HALT -> RUN when cpu_halted=0. The transition is registered, so the CPU is first eligible for a grant in the following cycle; starve_cnt is cleared.
- Simultaneous events: cpu_halted rising in the same cycle as a dm read grant is legal. The read completes, then HALT is entered.
- Address: no range check; ADDR_W bits are passed through.

Decomposition:
- Package mips_mem_pkg holds:
  - owner_t enum {NONE, IF, DM, DBG}
  - arb_state_t enum {RUN, HALT}
  - default ADDR_W / DATA_W constants
- Sub-module mips_prio_pick: combinational 3-way priority select.
  - Inputs: req vector, starve flag, halt_mode.
  - Output: one-hot grant.
  - The top level holds the FSM, starve_cnt, rd_owner and the return-data mux.

Test Plan:
- Reset: assert rst in the cycle after an IF read grant -> no if_rvalid; all gnt, rvalid and mem_en are 0 while rst=1.
- IF alone: if_req, if_addr=0, memory holds 32'h28010078 -> if_gnt=1 and mem_addr=0 in the same cycle; if_rvalid=1 with if_rdata=32'h28010078 one cycle later.
- Conflict: dm write addr 121 data 130 plus if_req addr 3 in the same cycle -> dm_gnt with mem_we=1 and mem_addr=121; if_gnt next cycle; MEM[121]=130.
- Starvation: dm_req and if_req held continuously for 12 cycles with STARVE_MAX=4 -> dm wins cycles 1-4, if wins cycle 5, then the pattern repeats (if wins cycle 10).
- Halt: dm read of addr 120 (value 85) granted while cpu_halted rises -> dm_rvalid with 85 next cycle, then halt_mode=1. A dbg read of 121 returns 130; if_req held high gets no grant. Dropping cpu_halted resumes IF grants in the next cycle.
- Debug in RUN: dbg_req with no CPU requests -> immediate grant; with dm_req present -> dbg waits until a cycle with no CPU request.

Source files
------------

// File: rtl/mips_mem_arbiter_pkg.sv
// rtl/mips_mem_arbiter_pkg.sv - shared types and constants for the unified-memory arbiter
package mips_mem_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Bit positions inside the {dbg, dm, if} request / grant vectors
  localparam int P_IF  = 0;
  localparam int P_DM  = 1;
  localparam int P_DBG = 2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DM   = 2'd2,
    DBG  = 2'd3
  } owner_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - requester and memory-port bundle for the arbiter
interface mips_mem_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips_mem_arbiter_prio_pick.sv
// rtl/mips_mem_arbiter_prio_pick.sv - one-hot 3-way priority select (dm > if > dbg)
module mips_prio_pick
  import mips_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  input  logic       halt_mode,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (halt_mode) begin
      gnt[P_DBG] = req[P_DBG];
    end else if (starve && req[P_IF]) begin
      gnt[P_IF] = 1'b1;
    end else if (req[P_DM]) begin
      gnt[P_DM] = 1'b1;
    end else if (req[P_IF]) begin
      gnt[P_IF] = 1'b1;
    end else if (req[P_DBG]) begin
      gnt[P_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory arbiter for IF, MEM-stage and debug requesters
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                cpu_halted,
  output logic                halt_mode,
  mips_mem_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_nx;
  owner_t            rd_owner, rd_owner_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;
  logic              starve;
  logic [2:0]        req, pick, gnt;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, dbg_rdata_q;
  logic              if_rvalid, dm_rvalid, dbg_rvalid;

  assign req       = {bus.dbg_req, bus.dm_req, bus.if_req};
  assign starve    = (starve_cnt == SW'(STARVE_MAX));
  assign halt_mode = (state == HALT);

  mips_prio_pick u_pick (
    .req       (req),
    .starve    (starve),
    .halt_mode (halt_mode),
    .gnt       (pick)
  );

  // Grants are combinational, so they must also be killed while reset is held
  assign gnt = rst ? 3'b000 : pick;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rd_owner_nx = NONE;
    if (gnt[P_IF]) begin
      mem_en      = 1'b1;
      mem_addr    = bus.if_addr;
      rd_owner_nx = IF;
    end else if (gnt[P_DM]) begin
      mem_en    = 1'b1;
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
      if (!bus.dm_we) rd_owner_nx = DM;
    end else if (gnt[P_DBG]) begin
      mem_en    = 1'b1;
      mem_we    = bus.dbg_we;
      mem_addr  = bus.dbg_addr;
      mem_wdata = bus.dbg_wdata;
      if (!bus.dbg_we) rd_owner_nx = DBG;
    end
  end

  // HALT is only entered once no CPU read granted this cycle is left in flight
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (cpu_halted && rd_owner_nx == NONE) state_nx = HALT;
      HALT:    if (!cpu_halted) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    starve_nx = starve_cnt;
    if (halt_mode || !bus.if_req || gnt[P_IF]) begin
      starve_nx = '0;
    end else if (!starve) begin
      starve_nx = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      rd_owner    <= NONE;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      starve_cnt <= starve_nx;
      rd_owner   <= rd_owner_nx;
      if (if_rvalid)  if_rdata_q  <= bus.mem_rdata;
      if (dm_rvalid)  dm_rdata_q  <= bus.mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= bus.mem_rdata;
    end
  end

  assign if_rvalid  = (rd_owner == IF);
  assign dm_rvalid  = (rd_owner == DM);
  assign dbg_rvalid = (rd_owner == DBG);

  assign bus.if_gnt     = gnt[P_IF];
  assign bus.dm_gnt     = gnt[P_DM];
  assign bus.dbg_gnt    = gnt[P_DBG];
  assign bus.if_rvalid  = if_rvalid;
  assign bus.dm_rvalid  = dm_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  // Read data passes straight through on rvalid and otherwise holds the last word
  assign bus.if_rdata   = if_rvalid  ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata   = dm_rvalid  ? bus.mem_rdata : dm_rdata_q;
  assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_rdata : dbg_rdata_q;

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed self-checking bench for mips_mem_arbiter
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  logic clk1;
  logic rst;
  logic cpu_halted;
  logic halt_mode;

  int n_chk  = 0;
  int n_fail = 0;

  mips_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .cpu_halted (cpu_halted),
    .halt_mode  (halt_mode),
    .bus        (bus)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Synchronous-read memory; unwritten words return their preload value
  logic [31:0] mem     [0:1023];
  logic        written [0:1023];

  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'd0:   return 32'h28010078;
      10'd3:   return 32'hDEAD0003;
      10'd120: return 32'd85;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] peek(input logic [9:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= peek(bus.mem_addr);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic settle();
    @(negedge clk1);
  endtask

  logic [31:0] word;
  logic [1:0]  got;
  logic [1:0]  want;

  initial begin
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;
    rst = 1'b1;
    cpu_halted = 1'b0;
    bus.if_req = 1'b1;  bus.if_addr = '0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // Reset state, with an IF request already pending
    settle();
    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst_dm_gnt", bus.dm_gnt, 1'b0);
    chk1("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("rst_halt_mode", halt_mode, 1'b0);
    chk32("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

    // IF alone
    cyc(); rst = 1'b0;
    settle();
    chk1("if_alone_gnt", bus.if_gnt, 1'b1);
    chk1("if_alone_mem_en", bus.mem_en, 1'b1);
    chk1("if_alone_mem_we", bus.mem_we, 1'b0);
    chk32("if_alone_mem_addr", 32'(bus.mem_addr), 32'd0);
    cyc(); bus.if_req = 1'b0;
    settle();
    chk1("if_alone_rvalid", bus.if_rvalid, 1'b1);
    chk32("if_alone_rdata", bus.if_rdata, 32'h28010078);
    chk1("if_alone_gnt_off", bus.if_gnt, 1'b0);
    cyc();
    settle();
    chk1("if_rvalid_single", bus.if_rvalid, 1'b0);
    chk32("if_rdata_hold", bus.if_rdata, 32'h28010078);

    // Reset in the cycle after an IF read grant drops the read
    cyc(); bus.if_req = 1'b1; bus.if_addr = 10'd3;
    settle();
    chk1("rst2_pre_gnt", bus.if_gnt, 1'b1);
    cyc(); rst = 1'b1;
    settle();
    chk1("rst2_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("rst2_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst2_mem_en", bus.mem_en, 1'b0);
    chk32("rst2_if_rdata", bus.if_rdata, 32'd0);
    cyc(); rst = 1'b0; bus.if_req = 1'b0;
    settle();
    chk1("rst2_no_late_rvalid", bus.if_rvalid, 1'b0);

    // dm write conflicts with IF fetch
    cyc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd121; bus.dm_wdata = 32'd130;
    bus.if_req = 1'b1; bus.if_addr = 10'd3;
    settle();
    chk1("conf_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("conf_if_gnt", bus.if_gnt, 1'b0);
    chk1("conf_mem_we", bus.mem_we, 1'b1);
    chk32("conf_mem_addr", 32'(bus.mem_addr), 32'd121);
    chk32("conf_mem_wdata", bus.mem_wdata, 32'd130);
    cyc(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    settle();
    chk1("conf_if_gnt_next", bus.if_gnt, 1'b1);
    chk32("conf_if_mem_addr", 32'(bus.mem_addr), 32'd3);
    chk1("conf_no_dm_rvalid", bus.dm_rvalid, 1'b0);
    cyc(); bus.if_req = 1'b0;
    settle();
    word = peek(10'd121);
    chk32("conf_mem121", word, 32'd130);
    chk1("conf_if_rvalid", bus.if_rvalid, 1'b1);
    chk32("conf_if_rdata", bus.if_rdata, 32'hDEAD0003);

    // Starvation: dm and IF held for 12 cycles
    cyc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd120;
    bus.if_req = 1'b1; bus.if_addr = 10'd0;
    for (int c = 1; c <= 12; c++) begin
      settle();
      got  = {bus.if_gnt, bus.dm_gnt};
      want = (c == 5 || c == 10) ? 2'b10 : 2'b01;
      chk32($sformatf("starve_c%0d", c), 32'(got), 32'(want));
      cyc();
    end
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    settle();

    // Halt entry behind an in-flight dm read
    cyc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd120;
    cpu_halted = 1'b1;
    settle();
    chk1("halt_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("halt_mode_pre", halt_mode, 1'b0);
    cyc(); bus.dm_req = 1'b0;
    settle();
    chk1("halt_dm_rvalid", bus.dm_rvalid, 1'b1);
    chk32("halt_dm_rdata", bus.dm_rdata, 32'd85);
    chk1("halt_mode_wait", halt_mode, 1'b0);
    cyc();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'd121;
    bus.if_req = 1'b1; bus.if_addr = 10'd0;
    bus.dm_req = 1'b1;
    settle();
    chk1("halt_mode_on", halt_mode, 1'b1);
    chk1("halt_dbg_gnt", bus.dbg_gnt, 1'b1);
    chk1("halt_if_blocked", bus.if_gnt, 1'b0);
    chk1("halt_dm_blocked", bus.dm_gnt, 1'b0);
    cyc(); bus.dbg_req = 1'b0; bus.dm_req = 1'b0;
    settle();
    chk1("halt_dbg_rvalid", bus.dbg_rvalid, 1'b1);
    chk32("halt_dbg_rdata", bus.dbg_rdata, 32'd130);
    chk1("halt_if_still_blocked", bus.if_gnt, 1'b0);
    cyc(); cpu_halted = 1'b0;
    settle();
    chk1("resume_halt_mode_held", halt_mode, 1'b1);
    chk1("resume_if_not_yet", bus.if_gnt, 1'b0);
    cyc();
    settle();
    chk1("resume_halt_mode_off", halt_mode, 1'b0);
    chk1("resume_if_gnt", bus.if_gnt, 1'b1);

    // Debug port in RUN
    cyc();
    bus.if_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'd200; bus.dbg_wdata = 32'd55;
    settle();
    chk1("dbg_run_gnt", bus.dbg_gnt, 1'b1);
    chk1("dbg_run_mem_we", bus.mem_we, 1'b1);
    chk32("dbg_run_mem_addr", 32'(bus.mem_addr), 32'd200);
    cyc();
    bus.dbg_we = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd5; bus.dm_wdata = 32'd7;
    settle();
    chk1("dbg_wait_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("dbg_wait_dbg_gnt", bus.dbg_gnt, 1'b0);
    cyc(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    settle();
    chk1("dbg_late_gnt", bus.dbg_gnt, 1'b1);
    chk1("dbg_late_mem_we", bus.mem_we, 1'b0);
    cyc(); bus.dbg_req = 1'b0;
    settle();
    chk1("dbg_rd_rvalid", bus.dbg_rvalid, 1'b1);
    chk32("dbg_rd_rdata", bus.dbg_rdata, 32'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
